// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer: word width, default tap count,
// counter widths and the sequencer state encoding.
package operand_sequencer_pkg;

    localparam int unsigned BIT_LENGTH = 16;
    localparam int unsigned TAPS_DEF   = 9;
    localparam int unsigned LIDX_W     = 4;
    localparam int unsigned EIDX_W     = 5;
    localparam int unsigned WINCNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_K = 2'd1,
        ST_FILL   = 2'd2,
        ST_EMIT   = 2'd3
    } state_e;

endpackage

// File: rtl/opseq_bank.sv
// DEPTH x WIDTH register file with one write port, one read port and a bulk clear.
// Used twice by operand_sequencer, once for the kernel and once for the pixel window.
module opseq_bank
    import operand_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = TAPS_DEF,
    parameter int unsigned WIDTH = BIT_LENGTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [LIDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [LIDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range reads return zero rather than X.
    assign rdata_o = (raddr_i < LIDX_W'(DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/operand_sequencer.sv
// Loads a 3x3 kernel once, then repeatedly loads pixel windows and streams
// interleaved pixel/kernel operand pairs into a MAC FIFO, honouring FULL back-pressure.
// Optional feature: define OPSEQ_WINCOUNT_EN to add the 16-bit winCount output.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int unsigned BITLEN = BIT_LENGTH,
    parameter int unsigned TAPS   = TAPS_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              cStart,
    input  logic [BITLEN-1:0] inData,
    input  logic              inValid,
    output logic              inReady,
    output logic [BITLEN-1:0] dataOut,
    output logic              wrEn,
    input  logic              FULL,
    output logic              windowDone,
    output logic              busy
`ifdef OPSEQ_WINCOUNT_EN
    ,
    output logic [WINCNT_W-1:0] winCount
`endif
);

    state_e              state_q, state_d;
    logic [LIDX_W-1:0]   lidx_q, lidx_d;
    logic [EIDX_W-1:0]   eidx_q, eidx_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                win_done_q, win_done_d;
    logic [BITLEN-1:0]   data_q, data_d;
    logic                accept;
    logic                wr_c;
    logic                bank_clr;
    logic                k_we, p_we;
    logic [BITLEN-1:0]   k_rd, p_rd;
`ifdef OPSEQ_WINCOUNT_EN
    logic [WINCNT_W-1:0] cnt_q, cnt_d;
`endif

    assign accept = inValid && in_ready_q;
    // The FIFO write is qualified by FULL in the same cycle, so it cannot be registered.
    assign wr_c   = (state_q == ST_EMIT) && !FULL;

    opseq_bank #(.DEPTH(TAPS), .WIDTH(BITLEN)) u_kbank (
        .clk     (Clk),
        .rst_n   (Rst),
        .clr_i   (bank_clr),
        .we_i    (k_we),
        .waddr_i (lidx_q),
        .wdata_i (inData),
        .raddr_i (eidx_d[EIDX_W-1:1]),
        .rdata_o (k_rd)
    );

    opseq_bank #(.DEPTH(TAPS), .WIDTH(BITLEN)) u_pbank (
        .clk     (Clk),
        .rst_n   (Rst),
        .clr_i   (bank_clr),
        .we_i    (p_we),
        .waddr_i (lidx_q),
        .wdata_i (inData),
        .raddr_i (eidx_d[EIDX_W-1:1]),
        .rdata_o (p_rd)
    );

    always_comb begin
        state_d    = state_q;
        lidx_d     = lidx_q;
        eidx_d     = eidx_q;
        win_done_d = 1'b0;
        bank_clr   = 1'b0;
        k_we       = 1'b0;
        p_we       = 1'b0;
        data_d     = data_q;
`ifdef OPSEQ_WINCOUNT_EN
        cnt_d      = cnt_q;
`endif
        if (cStart) begin
            state_d  = ST_LOAD_K;
            lidx_d   = '0;
            eidx_d   = '0;
            bank_clr = 1'b1;
`ifdef OPSEQ_WINCOUNT_EN
            cnt_d    = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_LOAD_K: begin
                    if (accept) begin
                        k_we = 1'b1;
                        if (lidx_q == LIDX_W'(TAPS - 1)) begin
                            lidx_d  = '0;
                            state_d = ST_FILL;
                        end else begin
                            lidx_d = lidx_q + LIDX_W'(1);
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        p_we = 1'b1;
                        if (lidx_q == LIDX_W'(TAPS - 1)) begin
                            lidx_d  = '0;
                            eidx_d  = '0;
                            state_d = ST_EMIT;
                        end else begin
                            lidx_d = lidx_q + LIDX_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (wr_c) begin
                        if (eidx_q == EIDX_W'(2 * TAPS - 1)) begin
                            eidx_d     = '0;
                            state_d    = ST_FILL;
                            win_done_d = 1'b1;
`ifdef OPSEQ_WINCOUNT_EN
                            cnt_d      = cnt_q + WINCNT_W'(1);
`endif
                        end else begin
                            eidx_d = eidx_q + EIDX_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Even emit slots carry the pixel (multiplier), odd slots the kernel word.
        if (state_d == ST_EMIT) begin
            data_d = eidx_d[0] ? k_rd : p_rd;
        end

        in_ready_d = (state_d == ST_LOAD_K) || (state_d == ST_FILL);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            lidx_q     <= '0;
            eidx_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            win_done_q <= 1'b0;
            data_q     <= '0;
`ifdef OPSEQ_WINCOUNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lidx_q     <= lidx_d;
            eidx_q     <= eidx_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            win_done_q <= win_done_d;
            data_q     <= data_d;
`ifdef OPSEQ_WINCOUNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign inReady    = in_ready_q;
    assign dataOut    = data_q;
    assign wrEn       = wr_c;
    assign windowDone = win_done_q;
    assign busy       = busy_q;
`ifdef OPSEQ_WINCOUNT_EN
    assign winCount   = cnt_q;
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed/randomized bench for operand_sequencer against a queue-based operand-order model.
// Define OPSEQ_WINCOUNT_EN to also check the window counter.
module tb_operand_sequencer;

    localparam int TAPS = 9;
    localparam int NW   = 2 * TAPS;

    logic        Clk = 1'b0;
    logic        Rst, cStart, inValid, FULL;
    logic [15:0] inData;
    logic        inReady, wrEn, windowDone, busy;
    logic [15:0] dataOut;
`ifdef OPSEQ_WINCOUNT_EN
    logic [15:0] winCount;
`endif

    always #5 Clk = ~Clk;

    operand_sequencer #(.BITLEN(16), .TAPS(TAPS)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .cStart     (cStart),
        .inData     (inData),
        .inValid    (inValid),
        .inReady    (inReady),
        .dataOut    (dataOut),
        .wrEn       (wrEn),
        .FULL       (FULL),
        .windowDone (windowDone),
        .busy       (busy)
`ifdef OPSEQ_WINCOUNT_EN
        ,
        .winCount   (winCount)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          win_wr  = 0;
    int          n_wd    = 0;
    int          exp_wd  = 0;
    int          win_model = 0;
    logic [15:0] exp_q[$];
    logic [15:0] kmod[TAPS];
    logic [15:0] pmod[TAPS];
    logic        s_wr, s_rdy, s_wd;
    logic [15:0] s_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample outputs 1ns after the falling edge, score writes, then advance one cycle.
    task automatic tick();
        logic [15:0] e;
        #1;
        s_wr   = wrEn;
        s_rdy  = inReady;
        s_dout = dataOut;
        s_wd   = windowDone;
        if (FULL) check("wr_while_full", 32'(wrEn), 32'(0));
        if (wrEn) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(dataOut), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_data", 32'(dataOut), 32'(e));
            end
            win_wr++;
        end
        if (windowDone) n_wd++;
        @(negedge Clk);
    endtask

    task automatic start();
        cStart = 1'b1;
        tick();
        cStart = 1'b0;
        win_model = 0;
        exp_q.delete();
        #1;
        check("start_ready", 32'(inReady), 32'(1));
        check("start_busy", 32'(busy), 32'(1));
    endtask

    task automatic send_word(input logic [15:0] d);
        logic done = 1'b0;
        for (int g = 0; g < 50 && !done; g++) begin
            inValid = ($urandom_range(0, 3) != 0);
            inData  = inValid ? d : 16'($urandom);
            tick();
            if (inValid && s_rdy) done = 1'b1;
        end
        inValid = 1'b0;
        if (!done) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic load_k();
        for (int i = 0; i < TAPS; i++) send_word(kmod[i]);
    endtask

    // Loading a window defines the next 18 writes: p0,k0,p1,k1,...
    task automatic load_p();
        for (int i = 0; i < TAPS; i++) pmod[i] = 16'($urandom);
        for (int i = 0; i < TAPS; i++) send_word(pmod[i]);
        for (int i = 0; i < TAPS; i++) begin
            exp_q.push_back(pmod[i]);
            exp_q.push_back(kmod[i]);
        end
    endtask

    task automatic run_emit(input int stop_at, input int stall_at, input int stall_len, input bit rnd);
        int stalls = 0;
        bit first = 1'b1;
        win_wr = 0;
        for (int g = 0; g < 300 && win_wr < stop_at; g++) begin
            if (win_wr == stall_at && stalls < stall_len) begin
                FULL = 1'b1;
                stalls++;
            end else if (rnd) begin
                FULL = ($urandom_range(0, 3) == 0);
            end else begin
                FULL = 1'b0;
            end
            tick();
            if (first && !FULL) check("first_emit_write", 32'(s_wr), 32'(1));
            if (FULL && win_wr == stall_at && exp_q.size() > 0)
                check("held_dout", 32'(s_dout), 32'(exp_q[0]));
            first = 1'b0;
        end
        FULL = 1'b0;
        check("emit_count", 32'(win_wr), 32'(stop_at));
    endtask

    task automatic tail_check();
        exp_wd++;
        win_model++;
        tick();
        check("window_done", 32'(s_wd), 32'(1));
        check("window_done_total", 32'(n_wd), 32'(exp_wd));
        check("ready_after_window", 32'(s_rdy), 32'(1));
        tick();
        check("window_done_one_cycle", 32'(s_wd), 32'(0));
        check("no_write_in_fill", 32'(s_wr), 32'(0));
`ifdef OPSEQ_WINCOUNT_EN
        check("win_count", 32'(winCount), 32'(win_model));
`endif
    endtask

    task automatic rand_kernel();
        for (int i = 0; i < TAPS; i++) kmod[i] = 16'($urandom);
    endtask

    initial begin
        Rst = 1'b0; cStart = 1'b0; inValid = 1'b0; FULL = 1'b0; inData = '0;
        repeat (3) @(negedge Clk);
        #1;
        check("rst_ready", 32'(inReady), 32'(0));
        check("rst_wren", 32'(wrEn), 32'(0));
        check("rst_done", 32'(windowDone), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_dout", 32'(dataOut), 32'(0));
        @(negedge Clk);
        Rst = 1'b1;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_accept", 32'(s_rdy), 32'(0));
        end
        inValid = 1'b0;

        // Window 1: known leading words, no back-pressure.
        start();
        rand_kernel();
        kmod[0] = 16'h4f72; kmod[1] = 16'h616a; kmod[2] = 16'h6ded;
        load_k();
        for (int i = 0; i < TAPS; i++) pmod[i] = 16'($urandom);
        pmod[0] = 16'h5015; pmod[1] = 16'h4958; pmod[2] = 16'h2525;
        for (int i = 0; i < TAPS; i++) send_word(pmod[i]);
        for (int i = 0; i < TAPS; i++) begin
            exp_q.push_back(pmod[i]);
            exp_q.push_back(kmod[i]);
        end
        run_emit(NW, -1, 0, 1'b0);
        tail_check();

        // Window 2 reuses the kernel, with a 3-cycle stall at emit index 5.
        load_p();
        run_emit(NW, 5, 3, 1'b0);
        tail_check();

        // Window 3 with random back-pressure.
        load_p();
        run_emit(NW, -1, 0, 1'b1);
        tail_check();

        // Abort at emit index 9: that write still lands, nothing after it.
        load_p();
        run_emit(9, -1, 0, 1'b0);
        cStart = 1'b1;
        tick();
        cStart = 1'b0;
        check("abort_last_write", 32'(s_wr), 32'(1));
        exp_q.delete();
        win_model = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_write", 32'(s_wr), 32'(0));
            check("abort_ready", 32'(s_rdy), 32'(1));
        end
        check("abort_no_done", 32'(n_wd), 32'(exp_wd));
`ifdef OPSEQ_WINCOUNT_EN
        check("win_count_cleared", 32'(winCount), 32'(0));
`endif

        // cStart coincident with an accept discards that word and restarts the load.
        for (int i = 0; i < 3; i++) send_word(16'($urandom));
        cStart = 1'b1; inValid = 1'b1; inData = 16'hdead;
        tick();
        cStart = 1'b0; inValid = 1'b0;
        rand_kernel();
        load_k();
        load_p();
        run_emit(NW, -1, 0, 1'b1);
        tail_check();

        // cStart coincident with the final write: write happens, no windowDone.
        load_p();
        run_emit(NW - 1, -1, 0, 1'b0);
        cStart = 1'b1;
        tick();
        cStart = 1'b0;
        check("final_write_on_start", 32'(s_wr), 32'(1));
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));
        tick();
        check("final_no_done", 32'(s_wd), 32'(0));
        check("final_ready", 32'(s_rdy), 32'(1));
        win_model = 0;

        // Reset asserted mid-EMIT clears outputs asynchronously.
        rand_kernel();
        load_k();
        load_p();
        run_emit(4, -1, 0, 1'b0);
        #2 Rst = 1'b0;
        #1;
        check("arst_wren", 32'(wrEn), 32'(0));
        check("arst_dout", 32'(dataOut), 32'(0));
        check("arst_ready", 32'(inReady), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        @(negedge Clk);
        Rst = 1'b1;
        exp_q.delete();
        win_model = 0;
        inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_write", 32'(s_wr), 32'(0));
            check("post_rst_no_ready", 32'(s_rdy), 32'(0));
        end
        inValid = 1'b0;
        start();
        rand_kernel();
        load_k();
        load_p();
        run_emit(NW, 7, 2, 1'b0);
        tail_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
